// File: rtl/tri_wireframe_raster.sv
// Midpoint wireframe rasterizer: walks V1->V2->V3->V1 and emits one
// pixel per cycle over pix_valid/pix_ready; off-screen pixels are clipped.
// Ports:
//   Clk, Reset_n         clock, async active-low reset
//   tri_valid/tri_ready  triangle handshake, proj_triangle [2]=V1 [1]=V2 [0]=V3
//   pix_valid/pix_ready  pixel handshake, pix_x/pix_y coordinate
//   busy                 not idle
//   done                 one-cycle pulse after the last pixel
module tri_wireframe_raster #(
    parameter int CW       = 10,
    parameter int SCREEN_W = 128,
    parameter int SCREEN_H = 128
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     tri_valid,
    output logic                     tri_ready,
    input  logic [2:0][1:0][CW-1:0]  proj_triangle,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [CW-1:0]            pix_x,
    output logic [CW-1:0]            pix_y,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t                    state, state_nxt;
    logic [2:0][1:0][CW-1:0]   verts;
    logic [1:0]                e;
    logic [CW-1:0]             x, y, dx, dy_mag;
    logic [CW-1:0]             x0, y0, x1, y1;
    logic [CW-1:0]             dx_new, dy_new;
    logic                      sx_neg, sy_neg;
    logic signed [CW+1:0]      err;
    logic signed [CW+2:0]      e2, dx_e, dy_e, err_w;
    logic                      on_screen, at_end, step_x, step_y;
    logic                      accept, load, consume, edge_next;

    always_comb begin
        x0 = verts[0][0];
        y0 = verts[0][1];
        x1 = verts[2][0];
        y1 = verts[2][1];
        case (e)
            2'd0: begin
                x0 = verts[2][0]; y0 = verts[2][1];
                x1 = verts[1][0]; y1 = verts[1][1];
            end
            2'd1: begin
                x0 = verts[1][0]; y0 = verts[1][1];
                x1 = verts[0][0]; y1 = verts[0][1];
            end
            default: ;
        endcase
    end

    assign dx_new = (x1 >= x0) ? x1 - x0 : x0 - x1;
    assign dy_new = (y1 >= y0) ? y1 - y0 : y0 - y1;

    assign on_screen = ({1'b0, x} < (CW+1)'(SCREEN_W))
                    && ({1'b0, y} < (CW+1)'(SCREEN_H));
    assign at_end    = (x == x1) && (y == y1);

    // dy is held as a magnitude; the signed form is -|dy|.
    assign e2     = $signed({err, 1'b0});
    assign dx_e   = $signed({3'b000, dx});
    assign dy_e   = -$signed({3'b000, dy_mag});
    assign step_x = (e2 >= dy_e);
    assign step_y = (e2 <= dx_e);
    assign err_w  = $signed({err[CW+1], err})
                  + (step_x ? dy_e : '0)
                  + (step_y ? dx_e : '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tri_ready = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        consume   = 1'b0;
        edge_next = 1'b0;
        unique case (state)
            IDLE: begin
                tri_ready = 1'b1;
                if (tri_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                load      = 1'b1;
                state_nxt = DRAW;
            end
            DRAW: begin
                consume = pix_ready || !on_screen;
                if (consume && at_end) begin
                    edge_next = 1'b1;
                    state_nxt = (e == 2'd2) ? DONE : SETUP;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign pix_valid = (state == DRAW) && on_screen;
    assign pix_x     = x;
    assign pix_y     = y;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            verts  <= '0;
            e      <= '0;
            x      <= '0;
            y      <= '0;
            dx     <= '0;
            dy_mag <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
            err    <= '0;
        end else begin
            if (accept) begin
                verts <= proj_triangle;
                e     <= '0;
            end
            if (load) begin
                x      <= x0;
                y      <= y0;
                dx     <= dx_new;
                dy_mag <= dy_new;
                sx_neg <= !(x0 < x1);
                sy_neg <= !(y0 < y1);
                err    <= $signed({2'b00, dx_new}) - $signed({2'b00, dy_new});
            end
            if (consume && !at_end) begin
                err <= err_w[CW+1:0];
                if (step_x) x <= sx_neg ? x - CW'(1) : x + CW'(1);
                if (step_y) y <= sy_neg ? y - CW'(1) : y + CW'(1);
            end
            if (edge_next && e != 2'd2) e <= e + 2'd1;
        end
    end

endmodule
